// File: rtl/alu_pkg.sv
// Shared encodings for the ALU issue controller: ALU control codes, MIPS
// opcode/funct values, FSM states and the decoded-operation record.
package alu_pkg;

    localparam logic [2:0] ALU_ADDU = 3'b000;
    localparam logic [2:0] ALU_ADD  = 3'b001;
    localparam logic [2:0] ALU_OR   = 3'b010;
    localparam logic [2:0] ALU_SUBU = 3'b100;
    localparam logic [2:0] ALU_SUB  = 3'b101;
    localparam logic [2:0] ALU_SLTU = 3'b110;
    localparam logic [2:0] ALU_SLT  = 3'b111;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_ADDIU = 6'b001001;
    localparam logic [5:0] OP_SLTI  = 6'b001010;
    localparam logic [5:0] OP_SLTIU = 6'b001011;
    localparam logic [5:0] OP_ORI   = 6'b001101;

    localparam logic [5:0] FN_ADD  = 6'b100000;
    localparam logic [5:0] FN_ADDU = 6'b100001;
    localparam logic [5:0] FN_SUB  = 6'b100010;
    localparam logic [5:0] FN_SUBU = 6'b100011;
    localparam logic [5:0] FN_OR   = 6'b100101;
    localparam logic [5:0] FN_SLT  = 6'b101010;
    localparam logic [5:0] FN_SLTU = 6'b101011;

    typedef enum logic [1:0] {
        B_RT   = 2'd0,
        B_SEXT = 2'd1,
        B_ZEXT = 2'd2
    } b_sel_t;

    typedef enum logic {
        DEST_RD = 1'b0,
        DEST_RT = 1'b1
    } dest_sel_t;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DECODE = 2'd1,
        EXEC   = 2'd2,
        RESP   = 2'd3
    } state_t;

    typedef struct packed {
        logic [2:0] alu_ctr;
        b_sel_t     b_sel;
        dest_sel_t  dest_sel;
        logic       is_branch;
        logic       legal;
    } dec_t;

endpackage

// File: rtl/alu_decode.sv
// Combinational MIPS decoder: maps opcode/funct onto ALU control, B-operand
// source, destination field and branch/legality flags.
module alu_decode
    import alu_pkg::*;
(
    input  logic [31:0] instr,
    output dec_t        dec
);

    logic [5:0] opcode;
    logic [5:0] funct;

    assign opcode = instr[31:26];
    assign funct  = instr[5:0];

    always_comb begin
        dec.alu_ctr   = ALU_ADDU;
        dec.b_sel     = B_RT;
        dec.dest_sel  = DEST_RD;
        dec.is_branch = 1'b0;
        dec.legal     = 1'b0;
        case (opcode)
            OP_RTYPE: begin
                dec.legal = 1'b1;
                case (funct)
                    FN_ADD:  dec.alu_ctr = ALU_ADD;
                    FN_ADDU: dec.alu_ctr = ALU_ADDU;
                    FN_SUB:  dec.alu_ctr = ALU_SUB;
                    FN_SUBU: dec.alu_ctr = ALU_SUBU;
                    FN_OR:   dec.alu_ctr = ALU_OR;
                    FN_SLT:  dec.alu_ctr = ALU_SLT;
                    FN_SLTU: dec.alu_ctr = ALU_SLTU;
                    default: dec.legal   = 1'b0;
                endcase
            end
            OP_ADDI, OP_ADDIU, OP_SLTI, OP_SLTIU: begin
                dec.legal    = 1'b1;
                dec.b_sel    = B_SEXT;
                dec.dest_sel = DEST_RT;
                case (opcode)
                    OP_ADDI:  dec.alu_ctr = ALU_ADD;
                    OP_SLTI:  dec.alu_ctr = ALU_SLT;
                    OP_SLTIU: dec.alu_ctr = ALU_SLTU;
                    default:  dec.alu_ctr = ALU_ADDU;
                endcase
            end
            OP_ORI: begin
                dec.legal    = 1'b1;
                dec.alu_ctr  = ALU_OR;
                dec.b_sel    = B_ZEXT;
                dec.dest_sel = DEST_RT;
            end
            OP_BEQ: begin
                // Equality comes from the ALU Zero flag on rs - rt
                dec.legal     = 1'b1;
                dec.alu_ctr   = ALU_SUBU;
                dec.is_branch = 1'b1;
                dec.dest_sel  = DEST_RT;
            end
            default: dec.legal = 1'b0;
        endcase
    end

endmodule

// File: rtl/alu_issue_ctrl.sv
// Issue/sequencer for the combinational ALU: accepts one instruction, drives
// the ALU for one EXEC cycle and returns a registered writeback response.
module alu_issue_ctrl
    import alu_pkg::*;
#(
    parameter int W  = 32,
    parameter int RW = 5
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [31:0]   in_instr,
    input  logic [W-1:0]  in_rs,
    input  logic [W-1:0]  in_rt,
    output logic [W-1:0]  alu_A,
    output logic [W-1:0]  alu_B,
    output logic [2:0]    alu_ALUctr,
    input  logic [W-1:0]  alu_Result,
    input  logic          alu_Zero,
    input  logic          alu_Overflow,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [W-1:0]  out_result,
    output logic [RW-1:0] out_rd,
    output logic          out_wen,
    output logic          out_taken,
    output logic          out_exc_ov,
    output logic          out_exc_ill
);

    state_t        state_reg, state_next;
    logic [31:0]   instr_reg;
    logic [W-1:0]  rs_reg, rt_reg;
    logic [W-1:0]  alu_a_reg, alu_b_reg;
    logic [2:0]    alu_ctr_reg;
    logic [RW-1:0] dest_reg;
    logic          is_branch_reg;
    logic [W-1:0]  out_result_reg;
    logic [RW-1:0] out_rd_reg;
    logic          out_wen_reg, out_taken_reg, out_exc_ov_reg, out_exc_ill_reg;

    dec_t          dec;
    logic [W-1:0]  b_value;
    logic [RW-1:0] dest_value;
    logic          unused_rs_field;

    alu_decode u_decode (
        .instr (instr_reg),
        .dec   (dec)
    );

    // The rs register index is not needed: its value arrives on in_rs
    assign unused_rs_field = ^instr_reg[25:21];

    always_comb begin
        case (dec.b_sel)
            B_SEXT:  b_value = {{(W-16){instr_reg[15]}}, instr_reg[15:0]};
            B_ZEXT:  b_value = {{(W-16){1'b0}}, instr_reg[15:0]};
            default: b_value = rt_reg;
        endcase
        dest_value = (dec.dest_sel == DEST_RT) ? instr_reg[20:16] : instr_reg[15:11];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    if (in_valid) state_next = DECODE;
            DECODE:  state_next = dec.legal ? EXEC : RESP;
            EXEC:    state_next = RESP;
            RESP:    if (out_ready) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            instr_reg       <= '0;
            rs_reg          <= '0;
            rt_reg          <= '0;
            alu_a_reg       <= '0;
            alu_b_reg       <= '0;
            alu_ctr_reg     <= '0;
            dest_reg        <= '0;
            is_branch_reg   <= 1'b0;
            out_result_reg  <= '0;
            out_rd_reg      <= '0;
            out_wen_reg     <= 1'b0;
            out_taken_reg   <= 1'b0;
            out_exc_ov_reg  <= 1'b0;
            out_exc_ill_reg <= 1'b0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (in_valid) begin
                        instr_reg <= in_instr;
                        rs_reg    <= in_rs;
                        rt_reg    <= in_rt;
                    end
                end
                DECODE: begin
                    // Illegal ops leave the ALU bus untouched and answer directly
                    if (dec.legal) begin
                        alu_a_reg     <= rs_reg;
                        alu_b_reg     <= b_value;
                        alu_ctr_reg   <= dec.alu_ctr;
                        dest_reg      <= dest_value;
                        is_branch_reg <= dec.is_branch;
                    end else begin
                        out_result_reg  <= '0;
                        out_rd_reg      <= '0;
                        out_wen_reg     <= 1'b0;
                        out_taken_reg   <= 1'b0;
                        out_exc_ov_reg  <= 1'b0;
                        out_exc_ill_reg <= 1'b1;
                    end
                end
                EXEC: begin
                    out_result_reg  <= alu_Result;
                    out_rd_reg      <= dest_reg;
                    out_wen_reg     <= !alu_Overflow && (dest_reg != '0) && !is_branch_reg;
                    out_taken_reg   <= is_branch_reg && alu_Zero;
                    out_exc_ov_reg  <= alu_Overflow;
                    out_exc_ill_reg <= 1'b0;
                end
                default: ;
            endcase
        end
    end

    // Gated by rst_n so every output reads 0 while reset is held
    assign in_ready    = rst_n && (state_reg == IDLE);
    assign out_valid   = (state_reg == RESP);
    assign alu_A       = alu_a_reg;
    assign alu_B       = alu_b_reg;
    assign alu_ALUctr  = alu_ctr_reg;
    assign out_result  = out_result_reg;
    assign out_rd      = out_rd_reg;
    assign out_wen     = out_wen_reg;
    assign out_taken   = out_taken_reg;
    assign out_exc_ov  = out_exc_ov_reg;
    assign out_exc_ill = out_exc_ill_reg;

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Scoreboard bench for alu_issue_ctrl with a behavioural ALU attached to the
// alu_* buses; directed instructions with hand-computed responses.
module tb_alu_issue_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid, in_ready;
    logic [31:0] in_instr, in_rs, in_rt;
    logic [31:0] alu_A, alu_B, alu_Result;
    logic [2:0]  alu_ALUctr;
    logic        alu_Zero, alu_Overflow;
    logic        out_valid, out_ready;
    logic [31:0] out_result;
    logic [4:0]  out_rd;
    logic        out_wen, out_taken, out_exc_ov, out_exc_ill;

    alu_issue_ctrl #(.W(32), .RW(5)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready), .in_instr(in_instr),
        .in_rs(in_rs), .in_rt(in_rt),
        .alu_A(alu_A), .alu_B(alu_B), .alu_ALUctr(alu_ALUctr),
        .alu_Result(alu_Result), .alu_Zero(alu_Zero), .alu_Overflow(alu_Overflow),
        .out_valid(out_valid), .out_ready(out_ready), .out_result(out_result),
        .out_rd(out_rd), .out_wen(out_wen), .out_taken(out_taken),
        .out_exc_ov(out_exc_ov), .out_exc_ill(out_exc_ill)
    );

    always #5 clk = ~clk;

    // Behavioural ALU; overflow only on signed add/sub
    always_comb begin
        alu_Result   = '0;
        alu_Overflow = 1'b0;
        case (alu_ALUctr)
            3'b000: alu_Result = alu_A + alu_B;
            3'b001: begin
                alu_Result   = alu_A + alu_B;
                alu_Overflow = (alu_A[31] == alu_B[31]) && (alu_Result[31] != alu_A[31]);
            end
            3'b010: alu_Result = alu_A | alu_B;
            3'b100: alu_Result = alu_A - alu_B;
            3'b101: begin
                alu_Result   = alu_A - alu_B;
                alu_Overflow = (alu_A[31] != alu_B[31]) && (alu_Result[31] != alu_A[31]);
            end
            3'b110: alu_Result = {31'd0, alu_A < alu_B};
            3'b111: alu_Result = {31'd0, $signed(alu_A) < $signed(alu_B)};
            default: alu_Result = '0;
        endcase
        alu_Zero = (alu_Result == 32'd0);
    end

    typedef struct {
        string       name;
        logic [31:0] result;
        logic [4:0]  rd;
        logic        chk_rd;
        logic        wen, taken, ov, ill;
        logic [2:0]  ctr;
        logic [31:0] b;
        int          lat;
    } exp_t;

    exp_t exp_q[$];
    int   n_tests = 0;
    int   n_fail  = 0;
    int   cyc     = 0;
    int   accept_cyc = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string nm, input logic [79:0] act, input logic [79:0] req);
        n_tests++;
        if (act !== req) begin
            n_fail++;
            $display("[TB] FAIL %s: got %0h, expected %0h", nm, act, req);
        end
    endtask

    function automatic logic [31:0] rtype(input logic [4:0] rs, input logic [4:0] rt,
                                          input logic [4:0] rd, input logic [5:0] fn);
        return {6'b000000, rs, rt, rd, 5'd0, fn};
    endfunction

    function automatic logic [31:0] itype(input logic [5:0] op, input logic [4:0] rs,
                                          input logic [4:0] rt, input logic [15:0] imm);
        return {op, rs, rt, imm};
    endfunction

    function automatic exp_t mk(input string nm, input logic [2:0] ctr, input logic [31:0] b,
                                input logic [31:0] res, input logic [4:0] rd, input logic chk_rd,
                                input logic wen, input logic taken, input logic ov,
                                input logic ill, input int lat);
        exp_t e;
        e.name = nm; e.ctr = ctr; e.b = b; e.result = res; e.rd = rd; e.chk_rd = chk_rd;
        e.wen = wen; e.taken = taken; e.ov = ov; e.ill = ill; e.lat = lat;
        return e;
    endfunction

    // Monitor: full check on first sight of a response, then stability while held
    logic        seen = 1'b0;
    logic [79:0] snap;
    always @(negedge clk) begin
        if (out_valid) begin
            if (!seen) begin
                seen = 1'b1;
                snap = {out_result, out_rd, out_wen, out_taken, out_exc_ov, out_exc_ill,
                        alu_ALUctr, alu_B};
                if (exp_q.size() == 0) begin
                    check("unexpected_resp", 80'd1, 80'd0);
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    $display("[TB] txn %s: result=%08h rd=%0d wen=%0b taken=%0b ov=%0b ill=%0b ctr=%03b B=%08h lat=%0d",
                             e.name, out_result, out_rd, out_wen, out_taken, out_exc_ov,
                             out_exc_ill, alu_ALUctr, alu_B, cyc + 1 - accept_cyc);
                    check({e.name, ".ctr"},    80'(alu_ALUctr), 80'(e.ctr));
                    check({e.name, ".B"},      80'(alu_B),      80'(e.b));
                    check({e.name, ".result"}, 80'(out_result), 80'(e.result));
                    check({e.name, ".wen"},    80'(out_wen),    80'(e.wen));
                    check({e.name, ".taken"},  80'(out_taken),  80'(e.taken));
                    check({e.name, ".ov"},     80'(out_exc_ov), 80'(e.ov));
                    check({e.name, ".ill"},    80'(out_exc_ill),80'(e.ill));
                    check({e.name, ".lat"},    80'(cyc + 1 - accept_cyc), 80'(e.lat));
                    if (e.chk_rd) check({e.name, ".rd"}, 80'(out_rd), 80'(e.rd));
                end
            end else begin
                check("hold_stable", {out_result, out_rd, out_wen, out_taken, out_exc_ov,
                                      out_exc_ill, alu_ALUctr, alu_B}, snap);
                check("hold_in_ready", 80'(in_ready), 80'd0);
            end
        end else begin
            seen = 1'b0;
        end
    end

    task automatic run_op(input logic [31:0] instr, input logic [31:0] rs,
                          input logic [31:0] rt, input int hold, input exp_t e);
        int n;
        n = 0;
        while (!in_ready && n < 20) begin @(posedge clk); #1; n++; end
        if (!in_ready) check({e.name, ".accept_timeout"}, 80'd0, 80'd1);
        in_instr = instr; in_rs = rs; in_rt = rt; in_valid = 1'b1;
        exp_q.push_back(e);
        @(posedge clk); #1;
        accept_cyc = cyc;
        in_valid = 1'b0;
        n = 0;
        while (!out_valid && n < 20) begin @(posedge clk); #1; n++; end
        if (!out_valid) check({e.name, ".resp_timeout"}, 80'd0, 80'd1);
        repeat (hold) begin @(posedge clk); #1; end
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n_valid;
        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        in_instr = '0; in_rs = '0; in_rt = '0;
        repeat (2) @(posedge clk);
        #1;
        check("reset.in_ready",  80'(in_ready),  80'd0);
        check("reset.out_valid", 80'(out_valid), 80'd0);
        check("reset.outs", {out_result, out_rd, out_wen, out_taken, out_exc_ov, out_exc_ill,
                             alu_ALUctr, alu_B}, 80'd0);
        check("reset.alu_A", 80'(alu_A), 80'd0);
        @(negedge clk); rst_n = 1'b1;
        #1;
        check("post_reset.in_ready", 80'(in_ready), 80'd1);

        run_op(rtype(5'd1, 5'd2, 5'd3, 6'h20), 32'h7FFFFFFF, 32'h1, 0,
               mk("add_ov",  3'b001, 32'h1, 32'h80000000, 5'd3, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 3));
        run_op(rtype(5'd1, 5'd2, 5'd4, 6'h21), 32'h7FFFFFFF, 32'h1, 5,
               mk("addu_bp", 3'b000, 32'h1, 32'h80000000, 5'd4, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 3));
        run_op(rtype(5'd1, 5'd2, 5'd5, 6'h2A), 32'hFFFFFFFF, 32'h1, 0,
               mk("slt",     3'b111, 32'h1, 32'h1, 5'd5, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 3));
        run_op(rtype(5'd1, 5'd2, 5'd6, 6'h2B), 32'hFFFFFFFF, 32'h1, 0,
               mk("sltu",    3'b110, 32'h1, 32'h0, 5'd6, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 3));
        run_op(itype(6'h0D, 5'd1, 5'd7, 16'hFFFF), 32'h0000F000, 32'h0, 0,
               mk("ori",     3'b010, 32'h0000FFFF, 32'h0000FFFF, 5'd7, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 3));
        run_op(itype(6'h09, 5'd1, 5'd8, 16'hFFFF), 32'h5, 32'h0, 0,
               mk("addiu",   3'b000, 32'hFFFFFFFF, 32'h4, 5'd8, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 3));
        run_op(itype(6'h04, 5'd1, 5'd2, 16'h0010), 32'h1234, 32'h1234, 0,
               mk("beq_t",   3'b100, 32'h1234, 32'h0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 3));
        run_op(itype(6'h3F, 5'd1, 5'd2, 16'h0000), 32'h55, 32'h66, 0,
               mk("ill_op",  3'b100, 32'h1234, 32'h0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2));
        run_op(rtype(5'd1, 5'd2, 5'd9, 6'h22), 32'h80000000, 32'h1, 0,
               mk("sub_ov",  3'b101, 32'h1, 32'h7FFFFFFF, 5'd9, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 3));
        run_op(rtype(5'd1, 5'd2, 5'd10, 6'h23), 32'h3, 32'h5, 0,
               mk("subu",    3'b100, 32'h5, 32'hFFFFFFFE, 5'd10, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 3));
        run_op(itype(6'h08, 5'd1, 5'd0, 16'hFFFE), 32'h10, 32'h0, 0,
               mk("addi_r0", 3'b001, 32'hFFFFFFFE, 32'hE, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 3));
        run_op(rtype(5'd1, 5'd2, 5'd3, 6'h00), 32'h1, 32'h2, 0,
               mk("ill_fn",  3'b001, 32'hFFFFFFFE, 32'h0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2));
        run_op(itype(6'h0A, 5'd1, 5'd12, 16'h0001), 32'hFFFFFFFF, 32'h0, 0,
               mk("slti",    3'b111, 32'h1, 32'h1, 5'd12, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 3));
        run_op(itype(6'h0B, 5'd1, 5'd13, 16'hFFFF), 32'h5, 32'h0, 0,
               mk("sltiu",   3'b110, 32'hFFFFFFFF, 32'h1, 5'd13, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 3));
        run_op(itype(6'h04, 5'd1, 5'd2, 16'h0010), 32'h1, 32'h2, 0,
               mk("beq_nt",  3'b100, 32'h2, 32'hFFFFFFFF, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 3));

        // Reset while the ALU is being driven: the transaction must vanish
        in_instr = rtype(5'd1, 5'd2, 5'd14, 6'h22); in_rs = 32'h5; in_rt = 32'h3;
        in_valid = 1'b1;
        @(posedge clk); #1; in_valid = 1'b0;
        @(posedge clk); #1;
        check("rst_exec.ctr_loaded", 80'(alu_ALUctr), 80'(3'b101));
        rst_n = 1'b0;
        #1;
        check("rst_exec.outs", {out_result, out_rd, out_wen, out_taken, out_exc_ov, out_exc_ill,
                                alu_ALUctr, alu_B}, 80'd0);
        check("rst_exec.valid_ready", {78'd0, out_valid, in_ready}, 80'd0);
        check("rst_exec.alu_A", 80'(alu_A), 80'd0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("rst_exec.idle", 80'(in_ready), 80'd1);
        n_valid = 0;
        repeat (8) begin @(posedge clk); #1; if (out_valid) n_valid++; end
        check("rst_exec.no_resp", 80'(n_valid), 80'd0);

        run_op(rtype(5'd1, 5'd2, 5'd11, 6'h25), 32'hF0, 32'h0F, 0,
               mk("or_after_rst", 3'b010, 32'h0F, 32'hFF, 5'd11, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 3));

        repeat (3) @(posedge clk);
        check("queue_empty", 80'(exp_q.size()), 80'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
